// File: rtl/clock_tree_model.sv
// Pixel-matrix clock/control distribution tree: four delayed paths fanned out
// to 16x16 pixels, with optional per-column skew.

module clock_tree_path #(
   parameter int D    = 4,
   parameter int SKEW = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         src,
   output logic [255:0] tap
);

   localparam int L = D + 15 * SKEW;

   logic [L-1:0] pipe;

   generate
      if (L > 1) begin : g_long
         always_ff @(posedge clk) begin
            if (rst) pipe <= '0;
            else     pipe <= {pipe[L-2:0], src};
         end
      end else begin : g_short
         always_ff @(posedge clk) begin
            if (rst) pipe <= '0;
            else     pipe <= src;
         end
      end
   endgenerate

   // Rows of one column share a single stage, so they never skew.
   for (genvar c = 0; c < 16; c++) begin : g_col
      assign tap[16*c +: 16] = {16{pipe[D - 1 + c * SKEW]}};
   end

endmodule

module clock_tree_model #(
   parameter int strobeDelay   = 4,
   parameter int clk40TDCDelay = 5,
   parameter int clk40RODelay  = 4,
   parameter int QInjDelay     = 5,
   parameter int colSkew       = 0
) (
   input  logic         clk1280,
   input  logic         rst,
   input  logic         TDC_Strobe_IN,
   input  logic         CLK40TDC_IN,
   input  logic         CLK40RO_IN,
   input  logic         ChargeInj_IN,
   output logic [255:0] TDC_Strobe_OUT,
   output logic [255:0] CLK40TDC_OUT,
   output logic [255:0] CLK40RO_OUT,
   output logic [255:0] ChargeInj_OUT
);

   clock_tree_path #(.D(strobeDelay), .SKEW(colSkew)) u_strobe (
      .clk (clk1280),
      .rst (rst),
      .src (TDC_Strobe_IN),
      .tap (TDC_Strobe_OUT)
   );

   clock_tree_path #(.D(clk40TDCDelay), .SKEW(colSkew)) u_clk40_tdc (
      .clk (clk1280),
      .rst (rst),
      .src (CLK40TDC_IN),
      .tap (CLK40TDC_OUT)
   );

   clock_tree_path #(.D(clk40RODelay), .SKEW(colSkew)) u_clk40_ro (
      .clk (clk1280),
      .rst (rst),
      .src (CLK40RO_IN),
      .tap (CLK40RO_OUT)
   );

   clock_tree_path #(.D(QInjDelay), .SKEW(colSkew)) u_charge_inj (
      .clk (clk1280),
      .rst (rst),
      .src (ChargeInj_IN),
      .tap (ChargeInj_OUT)
   );

endmodule

// File: tb/tb_clock_tree_model.sv
// Randomised and directed bench for clock_tree_model, checked against a
// sample-history reference model for a default and a skewed instance.

module tb_clock_tree_model;

   localparam int MAXC = 8192;
   localparam logic [255:0] ONES = {256{1'b1}};

   logic clk1280 = 1'b0;
   logic rst = 1'b1;
   logic tdc_strobe = 1'b1;
   logic clk40_tdc = 1'b1;
   logic clk40_ro = 1'b1;
   logic charge_inj = 1'b1;

   logic [255:0] a_strobe, a_tdc, a_ro, a_charge;
   logic [255:0] b_strobe, b_tdc, b_ro, b_charge;

   logic hist [4][MAXC];
   logic rst_at [MAXC];
   int   n = 0;
   int   tests = 0;
   int   failed = 0;

   always #5 clk1280 = ~clk1280;

   clock_tree_model dut_a (
      .clk1280        (clk1280),
      .rst            (rst),
      .TDC_Strobe_IN  (tdc_strobe),
      .CLK40TDC_IN    (clk40_tdc),
      .CLK40RO_IN     (clk40_ro),
      .ChargeInj_IN   (charge_inj),
      .TDC_Strobe_OUT (a_strobe),
      .CLK40TDC_OUT   (a_tdc),
      .CLK40RO_OUT    (a_ro),
      .ChargeInj_OUT  (a_charge)
   );

   clock_tree_model #(
      .strobeDelay   (4),
      .clk40TDCDelay (1),
      .clk40RODelay  (7),
      .QInjDelay     (3),
      .colSkew       (2)
   ) dut_b (
      .clk1280        (clk1280),
      .rst            (rst),
      .TDC_Strobe_IN  (tdc_strobe),
      .CLK40TDC_IN    (clk40_tdc),
      .CLK40RO_IN     (clk40_ro),
      .ChargeInj_IN   (charge_inj),
      .TDC_Strobe_OUT (b_strobe),
      .CLK40TDC_OUT   (b_tdc),
      .CLK40RO_OUT    (b_ro),
      .ChargeInj_OUT  (b_charge)
   );

   task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s cycle=%0d got=%h exp=%h", tag, n, got, exp);
      end
   endtask

   // Bit i shows the sample taken d+col*skew edges ago, unless a reset edge
   // occurred since that sample was taken.
   function automatic logic [255:0] model_bus(int p, int d, int skew);
      logic [255:0] r;
      logic v;
      int m;
      r = '0;
      for (int c = 0; c < 16; c++) begin
         m = n - d - c * skew;
         v = 1'b0;
         if (m >= 0) begin
            v = hist[p][m];
            for (int j = m; j < n; j++)
               if (rst_at[j]) v = 1'b0;
         end
         r[16*c +: 16] = {16{v}};
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk1280);
      if (n >= MAXC) begin
         $display("FAIL history_overflow cycle=%0d limit=%0d", n, MAXC);
         $fatal(1, "history overflow");
      end
      hist[0][n] = tdc_strobe;
      hist[1][n] = clk40_tdc;
      hist[2][n] = clk40_ro;
      hist[3][n] = charge_inj;
      rst_at[n] = rst;
      n++;
      #1;
      check("a_strobe", a_strobe, model_bus(0, 4, 0));
      check("a_tdc", a_tdc, model_bus(1, 5, 0));
      check("a_ro", a_ro, model_bus(2, 4, 0));
      check("a_charge", a_charge, model_bus(3, 5, 0));
      check("b_strobe", b_strobe, model_bus(0, 4, 2));
      check("b_tdc", b_tdc, model_bus(1, 1, 2));
      check("b_ro", b_ro, model_bus(2, 7, 2));
      check("b_charge", b_charge, model_bus(3, 3, 2));
   endtask

   task automatic all_inputs(logic v);
      tdc_strobe = v;
      clk40_tdc  = v;
      clk40_ro   = v;
      charge_inj = v;
   endtask

   initial begin
      int cnt_a0, cnt_a255, cnt_b255;
      int first [4];

      // Reset with every input high
      rst = 1'b1;
      all_inputs(1'b1);
      repeat (3) step();
      check("rst_strobe", a_strobe, '0);
      check("rst_tdc", a_tdc, '0);
      check("rst_ro", a_ro, '0);
      check("rst_charge", a_charge, '0);

      rst = 1'b0;
      repeat (3) step();
      check("rel3_strobe", a_strobe, '0);
      check("rel3_ro", a_ro, '0);
      step();
      check("rel4_strobe", a_strobe, ONES);
      check("rel4_ro", a_ro, ONES);
      check("rel4_tdc", a_tdc, '0);
      check("rel4_charge", a_charge, '0);
      step();
      check("rel5_tdc", a_tdc, ONES);
      check("rel5_charge", a_charge, ONES);
      repeat (40) step();

      // Periodic clocks
      all_inputs(1'b0);
      for (int i = 0; i < 128; i++) begin
         tdc_strobe = i[1];
         clk40_tdc  = i[4];
         clk40_ro   = i[4];
         step();
      end

      // Charge injection: 1-cycle then 1280-cycle pulse
      all_inputs(1'b0);
      repeat (80) step();
      cnt_a0 = 0;
      cnt_a255 = 0;
      cnt_b255 = 0;
      for (int i = 0; i < 1391; i++) begin
         charge_inj = (i == 0) || (i >= 21 && i < 1301);
         step();
         cnt_a0   += int'(a_charge[0]);
         cnt_a255 += int'(a_charge[255]);
         cnt_b255 += int'(b_charge[255]);
      end
      check("pulse_cnt_a0", 256'(cnt_a0), 256'(1281));
      check("pulse_cnt_a255", 256'(cnt_a255), 256'(1281));
      check("pulse_cnt_b255", 256'(cnt_b255), 256'(1281));

      // Column skew on a strobe step
      all_inputs(1'b0);
      repeat (60) step();
      for (int k = 0; k < 4; k++) first[k] = -1;
      tdc_strobe = 1'b1;
      for (int i = 1; i <= 45; i++) begin
         step();
         if (first[0] < 0 && b_strobe[0])   first[0] = i;
         if (first[1] < 0 && b_strobe[16])  first[1] = i;
         if (first[2] < 0 && b_strobe[240]) first[2] = i;
         if (first[3] < 0 && b_strobe[255]) first[3] = i;
      end
      check("skew_col0", 256'(first[0]), 256'(4));
      check("skew_col1", 256'(first[1]), 256'(6));
      check("skew_bit240", 256'(first[2]), 256'(34));
      check("skew_bit255", 256'(first[3]), 256'(34));

      // Mid-operation reset discards an in-flight pulse
      all_inputs(1'b0);
      repeat (60) step();
      cnt_a0 = 0;
      charge_inj = 1'b1;
      repeat (3) step();
      cnt_a0 += int'(a_charge[0]);
      charge_inj = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         cnt_a0 += int'(a_charge[0]);
      end
      check("midrst_cnt", 256'(cnt_a0), 256'(0));
      cnt_a0 = 0;
      charge_inj = 1'b1;
      repeat (2) step();
      cnt_a0 += int'(a_charge[0]);
      charge_inj = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         cnt_a0 += int'(a_charge[0]);
      end
      check("postrst_cnt", 256'(cnt_a0), 256'(2));

      // Independence: single pulses on separate cycles
      for (int p = 0; p < 4; p++) begin
         all_inputs(1'b0);
         case (p)
            0: tdc_strobe = 1'b1;
            1: clk40_tdc  = 1'b1;
            2: clk40_ro   = 1'b1;
            default: charge_inj = 1'b1;
         endcase
         step();
         all_inputs(1'b0);
         repeat (9) step();
      end
      repeat (60) step();

      // Random traffic with occasional resets
      for (int i = 0; i < 2000; i++) begin
         tdc_strobe = 1'($urandom);
         clk40_tdc  = 1'($urandom);
         clk40_ro   = 1'($urandom);
         charge_inj = 1'($urandom);
         rst = ($urandom_range(63) == 0);
         step();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
